// File: rtl/mac_pkg.sv
// mac_pkg: types and default sizes shared by the MAC sequencer slice.
//   mac_seq_state_t : sequencer FSM state encoding
//   DEF_*           : default operand, accumulator and length widths
package mac_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    CAPT,
    DONE
  } mac_seq_state_t;

endpackage

// File: rtl/mac_seq_mac.sv
// mac: signed multiply-accumulate with no clear input.
//   clk, rst_n : clock, asynchronous active-low reset (clears acc)
//   en         : accumulate a*b on this edge
//   a, b       : signed operands
//   acc        : running signed accumulator, wraps modulo 2^ACC_W
module mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_reg;

  // Full-width product, then sign-extended to the accumulator width.
  assign prod     = a * b;
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + prod_ext;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/mac_seq.sv
// mac_seq: dot-product sequencer around one mac instance.
//   cmd_valid/cmd_ready/cmd_len : length command (number of operand pairs)
//   in_valid/in_ready/in_a/in_b : signed operand pair stream
//   res_valid/res_ready/res_data: signed dot product result
//   busy                        : high whenever the FSM is not idle
// The mac cannot be cleared, so the accumulator is snapshotted when a
// command is accepted and the result is the wrapped difference.
module mac_seq
  import mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [ACC_W-1:0]  res_data,
  output logic                     busy
);

  mac_seq_state_t           state_reg;
  logic [LEN_W-1:0]         cnt_reg;
  logic [ACC_W-1:0]         base_reg;
  logic [ACC_W-1:0]         res_data_reg;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic                     mac_en_q;
  logic                     cmd_ready_reg;
  logic                     in_ready_reg;
  logic                     res_valid_reg;
  logic                     busy_reg;
  logic signed [ACC_W-1:0]  acc;

  mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (mac_en_q),
    .a    (mac_a),
    .b    (mac_b),
    .acc  (acc)
  );

  // Handshake outputs are registered alongside the state so they depend on
  // state only, never on the valid inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      base_reg      <= '0;
      res_data_reg  <= '0;
      mac_a         <= '0;
      mac_b         <= '0;
      mac_en_q      <= 1'b0;
      cmd_ready_reg <= 1'b1;
      in_ready_reg  <= 1'b0;
      res_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          mac_en_q <= 1'b0;
          if (cmd_valid) begin
            base_reg      <= acc;
            cnt_reg       <= cmd_len;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (cmd_len == '0) begin
              res_data_reg  <= '0;
              res_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              in_ready_reg <= 1'b1;
              state_reg    <= RUN;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            mac_a    <= in_a;
            mac_b    <= in_b;
            mac_en_q <= 1'b1;
            cnt_reg  <= cnt_reg - LEN_W'(1);
            if (cnt_reg == LEN_W'(1)) begin
              in_ready_reg <= 1'b0;
              state_reg    <= DRAIN;
            end
          end else begin
            mac_en_q <= 1'b0;
          end
        end
        DRAIN: begin
          // The final enable pulse is consumed by the mac on this edge.
          mac_en_q  <= 1'b0;
          state_reg <= CAPT;
        end
        CAPT: begin
          // Modular subtraction gives the right sum even if acc wrapped.
          res_data_reg  <= acc - base_reg;
          res_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          mac_en_q      <= 1'b0;
          cmd_ready_reg <= 1'b1;
          in_ready_reg  <= 1'b0;
          res_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign in_ready  = in_ready_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed test of mac_seq with a transaction-level model.
// Two instances share all stimulus: default widths and a 16-bit
// accumulator variant used for the wrap case.
module tb_mac_seq;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [7:0]        cmd_len = '0;
  logic              in_valid = 1'b0;
  logic signed [7:0] in_a = '0;
  logic signed [7:0] in_b = '0;
  logic              res_ready = 1'b0;

  logic               cmd_ready, in_ready, res_valid, busy;
  logic signed [31:0] res_data;
  logic               cmd_ready16, in_ready16, res_valid16, busy16;
  logic signed [15:0] res_data16;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mac_seq #(.DATA_W(8), .ACC_W(32), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  mac_seq #(.DATA_W(8), .ACC_W(16), .LEN_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready16), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .res_valid(res_valid16), .res_ready(res_ready), .res_data(res_data16),
    .busy(busy16)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 collecting pairs, 2 result pending,
  // 3 result presented. Result is the plain integer sum of products.
  int     m_phase = 0;
  int     m_rem   = 0;
  int     m_wait  = 0;
  longint m_sum   = 0;
  longint m_res   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_rem   <= 0;
      m_wait  <= 0;
      m_sum   <= 0;
      m_res   <= 0;
    end else begin
      case (m_phase)
        0: if (cmd_valid) begin
          m_sum <= 0;
          if (cmd_len == 8'd0) begin
            m_res   <= 0;
            m_phase <= 3;
          end else begin
            m_rem   <= int'(cmd_len);
            m_phase <= 1;
          end
        end
        1: if (in_valid) begin
          m_sum <= m_sum + longint'(in_a) * longint'(in_b);
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin
            m_wait  <= 2;
            m_phase <= 2;
          end
        end
        2: begin
          if (m_wait == 1) begin
            m_res   <= m_sum;
            m_phase <= 3;
          end else begin
            m_wait <= m_wait - 1;
          end
        end
        default: if (res_ready) m_phase <= 0;
      endcase
    end
  end

  function automatic longint exp32(input longint v);
    logic [31:0] t;
    t = v[31:0];
    return longint'($signed(t));
  endfunction

  function automatic longint exp16(input longint v);
    logic [15:0] t;
    t = v[15:0];
    return longint'($signed(t));
  endfunction

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    chk("cmd_ready",   cmd_ready,   longint'(m_phase == 0));
    chk("in_ready",    in_ready,    longint'(m_phase == 1));
    chk("res_valid",   res_valid,   longint'(m_phase == 3));
    chk("busy",        busy,        longint'(m_phase != 0));
    chk("res_data",    res_data,    exp32(m_res));
    chk("cmd_ready16", cmd_ready16, longint'(m_phase == 0));
    chk("in_ready16",  in_ready16,  longint'(m_phase == 1));
    chk("res_valid16", res_valid16, longint'(m_phase == 3));
    chk("busy16",      busy16,      longint'(m_phase != 0));
    chk("res_data16",  res_data16,  exp16(m_res));
  end

  // All tasks start and end just after a falling edge.
  task automatic send_cmd(input int len);
    int t;
    t = 0;
    cmd_valid = 1'b1;
    cmd_len   = 8'(len);
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_timeout", longint'(t < 50), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_pair(input int a, input int b, input int gap);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_a     = 8'(a);
    in_b     = 8'(b);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("pair_timeout", longint'(t < 50), 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Wait for res_valid, hold res_ready low for 'hold' cycles while poking
  // cmd_valid/in_valid (which must be ignored), then check and consume.
  task automatic take_res(input string name, input longint exp, input int hold);
    int t;
    t = 0;
    while (!res_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_timeout"}, longint'(t < 50), 1);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      in_valid  = 1'b1;
      @(negedge clk);
      chk({name, "_hold"}, res_data, exp32(exp));
    end
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    chk({name, "_dut"}, res_data, exp32(exp));
    chk({name, "_model"}, m_res, exp);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_res_data", res_data, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Basic product: 3*4 + 5*-2 = 2
    send_cmd(2);
    send_pair(3, 4, 0);
    send_pair(5, -2, 0);
    take_res("basic", 2, 0);

    // Non-zero accumulator: 16384 + 16129 - 1 = 32512
    send_cmd(3);
    send_pair(-128, -128, 0);
    send_pair(127, 127, 0);
    send_pair(-1, 1, 0);
    take_res("second", 32512, 0);

    // Bubbles and result backpressure: 100 - 60 + 1 + 0 = 41
    send_cmd(4);
    send_pair(10, 10, 1);
    send_pair(-20, 3, 1);
    send_pair(1, 1, 1);
    send_pair(0, 99, 1);
    take_res("bubble", 41, 5);

    // Zero length with pairs offered the whole time
    in_valid = 1'b1;
    in_a = 8'sd5;
    in_b = 8'sd5;
    cmd_valid = 1'b1;
    cmd_len = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("zero_valid", res_valid, 1);
    chk("zero_in_ready", in_ready, 0);
    take_res("zero", 0, 2);

    // Wrap: 3 * 16129 = 48387, which is -17149 modulo 2^16
    send_cmd(3);
    send_pair(127, 127, 0);
    send_pair(127, 127, 0);
    send_pair(127, 127, 0);
    while (!res_valid16) @(negedge clk);
    chk("wrap16_dut", res_data16, -17149);
    take_res("wrap32", 48387, 0);

    // Maximum length: 255 pairs of (1,-1)
    send_cmd(255);
    for (int i = 0; i < 255; i++) send_pair(1, -1, 0);
    take_res("maxlen", -255, 1);

    // Reset in the middle of RUN
    send_cmd(5);
    send_pair(2, 2, 0);
    send_pair(3, 3, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_res_data", res_data, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send_cmd(1);
    send_pair(7, -3, 0);
    take_res("post_reset", -21, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
